// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges of N_CH asynchronous inputs over a common gate of GATE_CYCLES clocks.
// Latency: input edge counted 3 clk later; results and gate_done 1 clk after the terminal cycle; readout +1 clk.
// Backpressure: none. Results are overwritten every gate, and enable low freezes results while the gate stays idle.
module clk_freq_meter #(
  parameter int N_CH        = 8,
  parameter int GATE_CYCLES = 125000000,
  parameter int CNT_W       = 32,
  parameter int LOSS_GATES  = 2,
  parameter int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  meas_in,
  input  logic             enable,
  input  logic             clear_minmax,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] freq,
  output logic [CNT_W-1:0] freq_min,
  output logic [CNT_W-1:0] freq_max,
  output logic [N_CH-1:0]  meas_valid,
  output logic [N_CH-1:0]  loss,
  output logic             gate_done,
  output logic             led_dbg
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int ZRUN_W = $clog2(LOSS_GATES + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [ZRUN_W-1:0] ZRUN_MAX  = ZRUN_W'(LOSS_GATES);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

  // Input synchronizers and edge detector
  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N_CH-1:0] prev_q, prev_d;
  logic [N_CH-1:0] rise_pls;

  // Gate timing
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic              terminal;
  logic              gate_done_q, gate_done_d;
  logic              led_q, led_d;

  // Per-channel counting and statistics
  logic [N_CH-1:0][CNT_W-1:0]  live_q, live_d, live_inc;
  logic [N_CH-1:0][CNT_W-1:0]  res_q, res_d;
  logic [N_CH-1:0][CNT_W-1:0]  min_q, min_d;
  logic [N_CH-1:0][CNT_W-1:0]  max_q, max_d;
  logic [N_CH-1:0]             first_q, first_d;
  logic [N_CH-1:0]             valid_q, valid_d;
  logic [N_CH-1:0]             loss_q, loss_d;
  logic [N_CH-1:0][ZRUN_W-1:0] zrun_q, zrun_d;

  // Readout registers
  logic [CNT_W-1:0] freq_q, freq_d;
  logic [CNT_W-1:0] fmin_q, fmin_d;
  logic [CNT_W-1:0] fmax_q, fmax_d;

  // Two-flop synchronizer, then a delayed copy to form a one-cycle rising-edge pulse.
  always_comb begin
    sync1_d  = meas_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    rise_pls = sync2_q & ~prev_q;
  end

  // Gate counter: runs 0..GATE_CYCLES-1 while enabled, held at 0 otherwise; gate_done is the registered terminal cycle.
  always_comb begin
    terminal    = enable && (gate_cnt_q == GATE_LAST);
    gate_cnt_d  = '0;
    if (enable && !terminal) begin
      gate_cnt_d = gate_cnt_q + 1'b1;
    end
    gate_done_d = terminal;
    led_d       = led_q ^ gate_done_q;
  end

  // Live edge counters saturate instead of wrapping; they restart at 0 after the terminal cycle so the
  // terminal-cycle edge lands in the result of the gate that is closing.
  always_comb begin
    live_inc = live_q;
    live_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rise_pls[i] && (live_q[i] != CNT_SAT)) begin
        live_inc[i] = live_q[i] + 1'b1;
      end
      if (enable && !terminal) begin
        live_d[i] = live_inc[i];
      end
    end
  end

  // Per-gate update of result, min/max, valid and loss-of-signal tracking.
  always_comb begin
    res_d   = res_q;
    min_d   = min_q;
    max_d   = max_q;
    first_d = first_q;
    valid_d = valid_q;
    zrun_d  = zrun_q;
    loss_d  = loss_q;
    for (int i = 0; i < N_CH; i++) begin
      if (terminal) begin
        res_d[i]   = live_inc[i];
        valid_d[i] = 1'b1;
        // A clear landing on the terminal cycle restarts tracking with this very result.
        if (first_q[i] || clear_minmax) begin
          min_d[i]   = live_inc[i];
          max_d[i]   = live_inc[i];
          first_d[i] = 1'b0;
        end else begin
          if (live_inc[i] < min_q[i]) begin
            min_d[i] = live_inc[i];
          end
          if (live_inc[i] > max_q[i]) begin
            max_d[i] = live_inc[i];
          end
        end
        if (live_inc[i] == '0) begin
          if (zrun_q[i] != ZRUN_MAX) begin
            zrun_d[i] = zrun_q[i] + 1'b1;
          end
        end else begin
          zrun_d[i] = '0;
        end
        loss_d[i] = (zrun_d[i] == ZRUN_MAX);
      end else if (clear_minmax) begin
        // Old min/max stay visible until the next result replaces them.
        first_d[i] = 1'b1;
      end
    end
  end

  // Registered readout mux; out-of-range selects read as zero.
  always_comb begin
    freq_d = '0;
    fmin_d = '0;
    fmax_d = '0;
    if (int'(sel) < N_CH) begin
      freq_d = res_q[sel];
      fmin_d = min_q[sel];
      fmax_d = max_q[sel];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      gate_cnt_q  <= '0;
      gate_done_q <= 1'b0;
      led_q       <= 1'b0;
      live_q      <= '0;
      res_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      first_q     <= '1;
      valid_q     <= '0;
      zrun_q      <= '0;
      loss_q      <= '0;
      freq_q      <= '0;
      fmin_q      <= '0;
      fmax_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      gate_cnt_q  <= gate_cnt_d;
      gate_done_q <= gate_done_d;
      led_q       <= led_d;
      live_q      <= live_d;
      res_q       <= res_d;
      min_q       <= min_d;
      max_q       <= max_d;
      first_q     <= first_d;
      valid_q     <= valid_d;
      zrun_q      <= zrun_d;
      loss_q      <= loss_d;
      freq_q      <= freq_d;
      fmin_q      <= fmin_d;
      fmax_q      <= fmax_d;
    end
  end

  assign freq       = freq_q;
  assign freq_min   = fmin_q;
  assign freq_max   = fmax_q;
  assign meas_valid = valid_q;
  assign loss       = loss_q;
  assign gate_done  = gate_done_q;
  assign led_dbg    = led_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: directed + randomized checks of clk_freq_meter against a window-sum reference model.
// Main instance: N_CH=4, CNT_W=32; second instance: N_CH=3, CNT_W=4 for saturation and out-of-range select.
// Both share clock, reset, enable and clear; gates are 100 clocks.
module tb_clk_freq_meter;
  localparam int GATE = 100;
  localparam int LOSS = 2;
  localparam int HMAX = 32768;

  logic        clk = 1'b0;
  logic        reset_n, enable, clear_minmax;
  logic [3:0]  meas_in;
  logic [1:0]  sel, sel_s;
  logic [31:0] freq, freq_min, freq_max;
  logic [3:0]  meas_valid, loss;
  logic        gate_done, led_dbg;
  logic [3:0]  freq_s, fmin_s, fmax_s;
  logic [2:0]  valid_s, loss_s;
  logic        gd_s, led_s;

  always #5 clk = ~clk;

  clk_freq_meter #(.N_CH(4), .GATE_CYCLES(GATE), .CNT_W(32), .LOSS_GATES(LOSS)) dut (
    .clk(clk), .reset_n(reset_n), .meas_in(meas_in), .enable(enable), .clear_minmax(clear_minmax),
    .sel(sel), .freq(freq), .freq_min(freq_min), .freq_max(freq_max), .meas_valid(meas_valid),
    .loss(loss), .gate_done(gate_done), .led_dbg(led_dbg));

  clk_freq_meter #(.N_CH(3), .GATE_CYCLES(GATE), .CNT_W(4), .LOSS_GATES(LOSS)) dut_s (
    .clk(clk), .reset_n(reset_n), .meas_in(meas_in[2:0]), .enable(enable), .clear_minmax(clear_minmax),
    .sel(sel_s), .freq(freq_s), .freq_min(fmin_s), .freq_max(fmax_s), .meas_valid(valid_s),
    .loss(loss_s), .gate_done(gd_s), .led_dbg(led_s));

  int tests = 0;
  int fails = 0;

  // Square-wave generators: half[c] clocks per phase, 0 = held low.
  int half[4];
  int phc[4];

  // Reference model state: a gate is any run of GATE consecutive enabled clock edges;
  // its count is the number of input rising edges seen (3-edge pipeline) across those edges.
  bit [3:0] hist[HMAX];
  int       pe = 3;
  int       run = 0;
  int       m_last_t = 0;
  longint   m_res[4], m_min[4], m_max[4];
  int       m_zr[4];
  bit       m_first[4];
  bit [3:0] m_valid, m_loss;
  bit       m_led;
  longint   s_res[4];
  longint   sum_m;

  always @(posedge clk) begin
    if (pe < HMAX - 1) pe = pe + 1;
    hist[pe] = meas_in;
    if (!reset_n) begin
      hist[pe] = '0; hist[pe-1] = '0; hist[pe-2] = '0;
      run = 0; m_valid = '0; m_loss = '0; m_led = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_res[c] = 0; m_min[c] = 0; m_max[c] = 0; m_zr[c] = 0; m_first[c] = 1'b1; s_res[c] = 0;
      end
    end else begin
      if (clear_minmax) for (int c = 0; c < 4; c++) m_first[c] = 1'b1;
      if (!enable) run = 0;
      else begin
        run = run + 1;
        if (run % GATE == 0) begin
          m_last_t = pe;
          m_led = ~m_led;
          for (int c = 0; c < 4; c++) begin
            sum_m = 0;
            for (int p = pe - GATE + 1; p <= pe; p++)
              if (hist[p-2][c] && !hist[p-3][c]) sum_m = sum_m + 1;
            m_res[c] = sum_m;
            s_res[c] = (sum_m > 15) ? 15 : sum_m;
            m_valid[c] = 1'b1;
            if (m_first[c]) begin
              m_min[c] = sum_m; m_max[c] = sum_m; m_first[c] = 1'b0;
            end else begin
              if (sum_m < m_min[c]) m_min[c] = sum_m;
              if (sum_m > m_max[c]) m_max[c] = sum_m;
            end
            if (sum_m == 0) begin
              if (m_zr[c] < LOSS) m_zr[c] = m_zr[c] + 1;
            end else m_zr[c] = 0;
            m_loss[c] = (m_zr[c] == LOSS);
          end
        end
      end
    end
  end

  initial begin
    meas_in = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (half[c] == 0) begin
          meas_in[c] = 1'b0; phc[c] = 0;
        end else begin
          phc[c] = phc[c] + 1;
          if (phc[c] >= half[c]) begin meas_in[c] = ~meas_in[c]; phc[c] = 0; end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for gate_done; cyc starts at 'start' for the current cycle.
  task automatic next_gate(input int start, output int cyc);
    cyc = start;
    while (gate_done !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_run(input int target);
    int k;
    k = 0;
    while ((run % GATE) != target && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic gate_checks(input string tag);
    chk({tag, "_gd"}, gate_done, 1);
    chk({tag, "_when"}, pe, m_last_t);
    chk({tag, "_valid"}, meas_valid, m_valid);
    chk({tag, "_loss"}, loss, m_loss);
    chk({tag, "_s_gd"}, gd_s, 1);
    chk({tag, "_s_valid"}, valid_s, m_valid[2:0]);
    chk({tag, "_s_loss"}, loss_s, m_loss[2:0]);
    @(negedge clk);
    chk({tag, "_gd_pulse"}, gate_done, 0);
    chk({tag, "_freq"}, freq, m_res[sel]);
    chk({tag, "_min"}, freq_min, m_min[sel]);
    chk({tag, "_max"}, freq_max, m_max[sel]);
    chk({tag, "_led"}, led_dbg, m_led);
    chk({tag, "_s_freq"}, freq_s, (sel_s < 3) ? s_res[sel_s] : 0);
  endtask

  int cyc;
  int seen;

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear_minmax = 1'b0; sel = '0; sel_s = '0;
    for (int c = 0; c < 4; c++) begin half[c] = 0; phc[c] = 0; end
    half[0] = 5;
    repeat (4) @(negedge clk);
    chk("rst_freq", freq, 0);
    chk("rst_min", freq_min, 0);
    chk("rst_max", freq_max, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_loss", loss, 0);
    chk("rst_gd", gate_done, 0);
    chk("rst_led", led_dbg, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_valid", meas_valid, 0);

    // 1: period-10 on channel 0, first gate latency and per-gate result
    enable = 1'b1;
    next_gate(1, cyc);
    chk("t1_latency", cyc, 101);
    gate_checks("t1g1");
    chk("t1_freq10", freq, 10);
    chk("t1_valid_all", meas_valid, 4'hf);
    chk("t1_loss1_g1", loss[1], 0);
    chk("t1_led_g1", led_dbg, 1);
    next_gate(0, cyc);
    gate_checks("t1g2");
    chk("t2_loss1_g2", loss[1], 1);
    chk("t1_led_g2", led_dbg, 0);

    // 2: channel 1 starts toggling with period 20
    half[1] = 10; sel = 2'd1;
    for (int g = 0; g < 3; g++) begin
      next_gate(0, cyc);
      gate_checks("t2");
    end
    chk("t2_loss1_clear", loss[1], 0);
    chk("t2_freq5", freq, 5);

    // 3: period 4 on channel 2 -> 25 edges, saturating to 15 in the 4-bit instance
    half[2] = 2; sel = 2'd2; sel_s = 2'd2;
    for (int g = 0; g < 2; g++) begin
      next_gate(0, cyc);
      gate_checks("t3");
    end
    chk("t3_freq25", freq, 25);
    chk("t3_sat15", freq_s, 15);
    sel_s = 2'd3;
    repeat (2) @(negedge clk);
    chk("t3_sel_oob", freq_s, 0);

    // 4: min/max tracking and clears
    sel = 2'd0;
    clear_minmax = 1'b1; @(negedge clk); clear_minmax = 1'b0;
    half[0] = 5;
    next_gate(0, cyc); gate_checks("t4a");
    half[0] = 2;
    next_gate(0, cyc); gate_checks("t4b");
    half[0] = 10;
    next_gate(0, cyc); gate_checks("t4c");
    next_gate(0, cyc); gate_checks("t4d");
    repeat (10) @(negedge clk);
    clear_minmax = 1'b1; @(negedge clk); clear_minmax = 1'b0;
    half[0] = 2;
    next_gate(0, cyc); gate_checks("t4clr");
    chk("t4clr_min_eq", freq_min, m_res[0]);
    chk("t4clr_max_eq", freq_max, m_res[0]);
    half[0] = 5;
    wait_run(GATE - 1);
    clear_minmax = 1'b1; @(negedge clk); clear_minmax = 1'b0;
    next_gate(0, cyc); gate_checks("t4term");
    chk("t4term_min", freq_min, m_res[0]);
    chk("t4term_max", freq_max, m_res[0]);

    // Randomized gates
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++)
        half[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 9));
      sel = 2'($urandom_range(0, 3));
      sel_s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        clear_minmax = 1'b1; @(negedge clk); clear_minmax = 1'b0;
      end
      next_gate(0, cyc);
      gate_checks("rnd");
    end

    // 5: enable dropped mid-gate, then re-asserted
    half[0] = 5; sel = 2'd0;
    wait_run(50);
    enable = 1'b0;
    seen = 0;
    repeat (150) begin @(negedge clk); if (gate_done) seen++; end
    chk("t5_no_gate", seen, 0);
    chk("t5_hold_freq", freq, m_res[0]);
    chk("t5_hold_valid", meas_valid, m_valid);
    enable = 1'b1;
    next_gate(1, cyc);
    chk("t5_latency", cyc, 101);
    gate_checks("t5");
    chk("t5_freq10", freq, 10);
    wait_run(GATE - 1);
    enable = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (gate_done) seen++; end
    chk("t5_term_drop", seen, 0);
    enable = 1'b1;

    // 6: one-cycle reset mid-gate
    wait_run(70);
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    chk("t6_freq", freq, 0);
    chk("t6_min", freq_min, 0);
    chk("t6_max", freq_max, 0);
    chk("t6_valid", meas_valid, 0);
    chk("t6_loss", loss, 0);
    chk("t6_gd", gate_done, 0);
    chk("t6_led", led_dbg, 0);
    next_gate(1, cyc);
    chk("t6_latency", cyc, 101);
    gate_checks("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
Multi-channel reference-clock frequency meter for board bring-up, the parametrised successor of the fixed 8-input clock counter in the system.
- Counts rising edges of up to N_CH asynchronous slow inputs over a common gate window of GATE_CYCLES system clocks.
- Per channel it latches the result and tracks min/max and loss-of-signal.
- Exposes one selectable channel on a registered readout port, plus a gate-rate debug LED.
- Inputs are pre-divided refclks or similar; the block runs entirely in the clk domain.

Parameters:
N_CH, 8, number of measured channels (1..32)
GATE_CYCLES, 125000000, gate window length in clk cycles (>= 4)
CNT_W, 32, width of edge counters and results
LOSS_GATES, 2, consecutive zero-count gates before loss is flagged (>= 1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
meas_in  in  N_CH  asynchronous measured signals; high and low phases each >= 2 clk cycles
enable  in  1  high = measure; low = hold results, gate stopped
clear_minmax  in  1  one-cycle pulse; restarts min/max tracking for all channels
sel  in  max(1,$clog2(N_CH))  readout channel select
freq  out  CNT_W  last gate result of channel sel
freq_min  out  CNT_W  minimum result of channel sel since reset/clear
freq_max  out  CNT_W  maximum result of channel sel since reset/clear
meas_valid  out  N_CH  bit set once channel has a completed gate result
loss  out  N_CH  loss-of-signal flags
gate_done  out  1  one-cycle pulse when results update
led_dbg  out  1  toggles on every gate_done

Behaviour:
- Reset (reset_n low at clk edge): synchronizers, gate counter and live counters clear; all results, min, max, meas_valid, loss, gate_done, led_dbg and the readout regs go to 0; minmax_first flags are set.
- Input path: 2-FF synchronizer, then a previous-value register. Rising-edge pulse edge[i] is asserted 3 clk cycles after the input edge.
- Gate counter:
  - Counts 0..GATE_CYCLES-1 while enable=1.
  - At GATE_CYCLES-1 it wraps to 0 and asserts gate_done on the following cycle (registered).
  - First gate_done is exactly GATE_CYCLES+1 cycles after the first enabled cycle.
- Live counters:
  - Increment on edge[i] and saturate at 2^CNT_W-1; no wrap.
  - On the terminal cycle, the result register is loaded with live count plus that cycle's edge (saturating).
  - The live counter then restarts at 0, so no edge is lost or double counted across the boundary.
- Per-gate update, applied on the same edge as the result load:
  - meas_valid[i] is set.
  - If minmax_first[i] or clear_minmax is asserted that cycle, min and max both load the new result and the flag clears. Otherwise min=min(min,res) and max=max(max,res).
  - Zero-run counter: increments (saturating at LOSS_GATES) on result 0, clears on nonzero result. loss[i]=1 while the counter equals LOSS_GATES; it clears at the first nonzero gate.
- clear_minmax outside a terminal cycle: sets every minmax_first flag. min/max outputs hold their old values until the next gate result.
- enable low:
  - Gate counter and live counters are held at 0.
  - Results, min/max, meas_valid and loss hold.
  - No gate_done is produced.
  - Re-assertion starts a fresh full window.
- enable dropping on the terminal cycle suppresses that gate: no update and no gate_done.
- Readout: freq, freq_min and freq_max are registered muxes of channel sel, 1-cycle latency. If sel >= N_CH they read 0.
- led_dbg: toggles on the cycle gate_done is high.
- Reset mid-gate discards the partial window, with no gate_done.

Test Plan (GATE_CYCLES=100, N_CH=4, CNT_W=32 unless noted):
1. enable=1; meas_in[0] square wave of period 10 clk, others idle -> gate_done 101 cycles after enable; freq(sel=0)=10 each gate; meas_valid=4'b1111; led_dbg toggles per gate.
2. Channel 1 idle with LOSS_GATES=2 -> loss[1]=0 after gate 1, =1 after gate 2. Then start period-20 toggling -> loss[1] clears at the first gate with result 5.
3. CNT_W=4; meas_in[2] period 4 (25 edges per gate) -> freq(sel=2)=15 (saturated).
4. Channel 0 periods 10, then 5, then 20 over three gates -> freq_min=5, freq_max=20. Pulse clear_minmax, next gate result 5 -> min=max=5. Pulse clear_minmax on a terminal cycle -> min=max=that gate's result.
5. Deassert enable at gate count 50 -> no gate_done and results unchanged. Re-assert -> next gate_done exactly 101 cycles later with full-window counts (10 for period 10).
6. reset_n low for 1 cycle at gate count 70 -> next cycle all outputs 0. After release with enable=1, first gate_done 101 cycles later.
